// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD display controller: FSM states,
// active-low segment patterns and the internal overflow digit code.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    CAPTURE
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0]  DIGIT_DASH = 4'hE;
  localparam logic [15:0] MAX_DISP   = 16'd9999;

  // Active-low anode pattern enabling only the digit at idx.
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_display_ctrl_if.sv
// Handshake between the display controller and the external binary-to-BCD
// converter; the controller is the master.
interface bcd_display_ctrl_if;

  logic        conv_valid;
  logic [15:0] conv_data;
  logic        conv_ready;
  logic [15:0] conv_bcd;

  modport master (
    output conv_valid,
    output conv_data,
    input  conv_ready,
    input  conv_bcd
  );

  modport slave (
    input  conv_valid,
    input  conv_data,
    output conv_ready,
    output conv_bcd
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational digit-to-segment decoder for a common-anode display.
// Non-decimal nibbles (including the overflow code) render as a dash.
module seg7_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Drives the multiplier result through the external BCD converter, keeps the
// converted digits and scans them onto a 4-digit common-anode display.
module bcd_display_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CONV_LAT    = 1,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          mult_result,
  input  logic                 mult_valid,
  bcd_display_ctrl_if.master   conv,
  output logic                 busy,
  output logic                 disp_valid,
  output logic                 ovf,
  output logic                 conv_err,
  output logic [3:0]           an,
  output logic [6:0]           seg
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] LAT_CNT      = CW'(CONV_LAT);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   wait_cnt;
  logic            pend_valid;
  logic [15:0]     pend_data;
  logic [15:0]     digits;
  logic [RW-1:0]   refresh_cnt;
  logic [1:0]      scan_idx;

  logic            req_valid;
  logic [15:0]     req_value;
  logic            load_conv;
  logic            take_ovf;
  logic            capture;
  logic            timeout;

  logic [3:0]      lz_above;
  logic [3:0]      cur_digit;
  logic            cur_blank;
  logic [6:0]      dec_seg;

  // A fresh pulse always beats a stored one, so the newest value wins.
  assign req_valid = mult_valid | pend_valid;
  assign req_value = mult_valid ? mult_result : pend_data;

  assign busy            = (state != IDLE);
  assign conv.conv_valid = (state == START);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_conv  = 1'b0;
    take_ovf   = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_value <= MAX_DISP) begin
            load_conv  = 1'b1;
            state_next = START;
          end else begin
            take_ovf = 1'b1;
          end
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        // wait_cnt holds the number of cycles elapsed since START.
        if (conv.conv_ready && (wait_cnt >= LAT_CNT)) begin
          state_next = CAPTURE;
        end else if (wait_cnt >= TIMEOUT_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      CAPTURE: begin
        capture    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conv.conv_data <= '0;
      wait_cnt       <= '0;
      pend_valid     <= 1'b0;
      pend_data      <= '0;
      digits         <= '0;
      disp_valid     <= 1'b0;
      ovf            <= 1'b0;
      conv_err       <= 1'b0;
    end else begin
      if (busy && mult_valid) begin
        pend_valid <= 1'b1;
        pend_data  <= mult_result;
      end else if (state == IDLE) begin
        pend_valid <= 1'b0;
      end

      if (load_conv) begin
        conv.conv_data <= req_value;
      end

      if (state == START) begin
        wait_cnt <= CW'(1);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end

      if (take_ovf) begin
        ovf        <= 1'b1;
        conv_err   <= 1'b0;
        digits     <= {4{DIGIT_DASH}};
        disp_valid <= 1'b1;
      end

      // A timeout keeps whatever digits were already on display.
      if (timeout) begin
        conv_err <= 1'b1;
        ovf      <= 1'b0;
      end

      if (capture) begin
        digits     <= conv.conv_bcd;
        disp_valid <= 1'b1;
        ovf        <= 1'b0;
        conv_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // lz_above[i] is set when digit i and every digit above it are zero.
  always_comb begin
    lz_above    = '0;
    lz_above[3] = (digits[15:12] == 4'd0);
    lz_above[2] = lz_above[3] && (digits[11:8] == 4'd0);
    lz_above[1] = lz_above[2] && (digits[7:4] == 4'd0);
    lz_above[0] = 1'b0;
    cur_digit   = digits[{scan_idx, 2'b00} +: 4];
    cur_blank   = (BLANK_LZ != 0) && lz_above[scan_idx];
  end

  seg7_decoder u_seg7_decoder (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (dec_seg)
  );

  assign seg = disp_valid ? dec_seg : SEG_BLANK;
  assign an  = disp_valid ? anode_for(scan_idx) : 4'b1111;

endmodule

// File: doc/bcd_display_ctrl.md
Name: bcd_display_ctrl

Overview:
Sequences the 16-bit multiplier result through the external binary-to-BCD converter and latches the converted digits. It then multiplexes them onto a 4-digit common-anode 7-segment display. The block sits between the multiplier output and the board display pins. It owns the converter handshake, overflow detection, leading-zero blanking and digit refresh.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit stays enabled (min 2)
CONV_LAT, 1, cycles after conv_valid before conv_ready is sampled (min 1)
TIMEOUT, 16, max cycles in WAIT for conv_ready before error (must exceed CONV_LAT)
BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all four digits

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low
mult_result  in  16  unsigned multiplier product
mult_valid  in  1  one-cycle pulse, mult_result valid
conv_valid  out  1  one-cycle start pulse to converter
conv_data  out  16  operand to converter, held stable from START through CAPTURE
conv_ready  in  1  converter done (may stay high; sampled only in WAIT)
conv_bcd  in  16  converter BCD result, 4 nibbles, [3:0] = units
busy  out  1  high in START/WAIT/CAPTURE
disp_valid  out  1  display shows a valid value (sticky until reset)
ovf  out  1  last accepted value > 9999
conv_err  out  1  last conversion timed out
an  out  4  digit enables, active-low, an[0] = units
seg  out  7  {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset: the clock is clk and the reset is reset, asynchronous, active-low. On reset: FSM=IDLE, conv_valid=0, conv_data=0, busy=0, disp_valid=0, ovf=0, conv_err=0, pending cleared, digit register=0, an=4'b1111, seg=7'b1111111, refresh counter=0, scan index=0.
- FSM states: IDLE, START, WAIT, CAPTURE.
- IDLE: on mult_valid, or when pending is set:
  - If the value is <= 9999: load conv_data and go to START.
  - If the value is > 9999: set ovf=1, conv_err=0, digits=DASH×4, disp_valid=1, stay in IDLE. Not sent to the converter.
- START: conv_valid=1 for exactly one cycle, then go to WAIT. Clear the latency and timeout counters.
- WAIT: conv_ready is ignored until CONV_LAT cycles have elapsed. After that, the first cycle with conv_ready=1 goes to CAPTURE. If conv_ready is not seen by TIMEOUT cycles after START: set conv_err=1, ovf=0, leave the digit register unchanged, go to IDLE.
- CAPTURE: latch conv_bcd into the digit register, set disp_valid=1, ovf=0, conv_err=0, go to IDLE. The display updates the next cycle.
- Latency: mult_valid to updated digit register = CONV_LAT+3 cycles minimum.
- mult_valid while busy: stored in a one-deep pending register. A newer pulse overwrites the older one (newest wins). The stored value is serviced on the first IDLE cycle.
- mult_valid in IDLE in the same cycle pending is set: the new value wins and pending is cleared.
- Refresh counter counts 0..REFRESH_DIV-1. On wrap, scan index increments 0→1→2→3→0. Exactly one an bit is low at a time once disp_valid=1. Before disp_valid=1, an stays 4'b1111.
- Digit decode (seg, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. DASH=0111111. BLANK=1111111. Nibbles A–F decode to DASH.
- Leading-zero blanking (BLANK_LZ=1): blank every digit above the most significant nonzero digit. The units digit is never blanked, so value 0 shows "0". Not applied to DASH.
- Reset mid-conversion: immediate return to the reset state. A conv_ready arriving later is ignored, because the FSM is not in WAIT.

Decomposition:
- Package bcd_disp_pkg:
  - state_t enum {IDLE, START, WAIT, CAPTURE}
  - 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK
  - nibble code DIGIT_DASH=4'hE, used internally for overflow
  - MAX_DISP=16'd9999
- Sub-module seg7_decoder: combinational, 4-bit digit + blank flag → 7-bit seg, so the decode is reusable and unit-testable. Top level keeps the FSM, pending register, refresh counter and scan mux.

Test Plan:
1. Reset, then mult_valid with 16'd1234; stub converter returns 16'h1234 with conv_ready 1 cycle after conv_valid. Expect one conv_valid pulse, conv_data=1234, disp_valid=1, ovf=0. Scan shows an=1110/seg=0011001 (4), 1101/0110000 (3), 1011/0100100 (2), 0111/1111001 (1), REFRESH_DIV=4.
2. mult_valid 16'd7, converter returns 16'h0007. With BLANK_LZ=1: units seg=1111000 and the other three digits seg=1111111. With value 0: only units shows 1000000.
3. mult_valid 16'd65025: no conv_valid, ovf=1, all four digits seg=0111111.
4. Stub converter never raises conv_ready, TIMEOUT=16: conv_err=1 exactly 16 cycles after START, FSM back in IDLE, previous digits still displayed.
5. Pulses 100, 200, 300 while busy on an earlier 50: after 50 completes, only 300 is converted (a single extra conv_valid), and the display ends at 300.
6. Reset asserted during WAIT, then released, then a late conv_ready=1: no capture, an=1111, seg=1111111, disp_valid=0.
